db15_serial_reader: RTL
=======================

// Module: db15_serial_reader
// PURPOSE
//  Polls a DB15 arcade-stick adapter (two chained 74x165 shift registers) over the
//  UserIO port: drives JOY_LOAD/JOY_CLK, shifts in one serial frame, then presents
//  two debounced active-high 16-bit joystick words to the top-level input mapping.
//  Bit layout: 0=R 1=L 2=D 3=U 4..11=buttons. It sits between USER_IN/USER_OUT and joystick muxing.
// PARAMETERS
//  CLK_DIV      4      MCLK cycles per tick; every serial phase lasts one tick (>=2)
//  FRAME_BITS   24     bits per frame; first half -> player 1, second half -> player 2
//  POLL_CYCLES  48000  MCLK cycles between frame starts (1 kHz at 48 MHz)
//  MATCH        1      1: update outputs only when two consecutive frames are equal
// PORTS
//  MCLK        in   1   system clock (40-50 MHz)
//  RESET       in   1   synchronous, active-high reset
//  JOY_DATA    in   1   serial data from adapter; active-low (0 = pressed)
//  JOY_CLK     out  1   shift clock to adapter
//  JOY_LOAD    out  1   parallel-load strobe, active-low
//  joystick1   out  16  player 1 buttons, active-high; [15:FRAME_BITS/2] = 0
//  joystick2   out  16  player 2 buttons, same layout
//  frame_done  out  1   one-MCLK pulse at end of every frame (committed or not)
//  busy        out  1   high while a frame is in progress
// BEHAVIOUR
//  Reset (sync, active-high): JOY_CLK=0, JOY_LOAD=1, joystick1/2=0, frame_done=0,
//   busy=0, poll counter=0, tick counter=0, shift reg=all-ones, prev frame=all-ones, state=IDLE.
//  Reset asserted mid-frame aborts the frame at once; no partial data reaches outputs.
//  Poll counter runs free 0..POLL_CYCLES-1 and wraps. At value POLL_CYCLES-1 in IDLE,
//   the next cycle enters LOAD. If a frame is still in progress, that poll is dropped (no queue).
//  Tick counter resets to 0 on each state entry. A tick ends when it reaches CLK_DIV-1.
//  FSM:
//   IDLE   JOY_LOAD=1, JOY_CLK=0, busy=0.
//   LOAD   JOY_LOAD=0 for 1 tick -> SETTLE.
//   SETTLE JOY_LOAD=1 for 1 tick; bit index k=0 -> SHLO.
//   SHLO   JOY_CLK=0 for 1 tick. On the last MCLK of the tick, shift ~JOY_DATA into frame bit k -> SHHI.
//   SHHI   JOY_CLK=1 for 1 tick. If k==FRAME_BITS-1 -> COMMIT, else k++ -> SHLO.
//   COMMIT 1 MCLK: frame_done=1. If MATCH=0, or captured==prev, load outputs.
//          Then prev<=captured -> IDLE.
//  Outputs are registered. JOY_CLK and JOY_LOAD come straight from flops, so no glitches.
//  Frame length = (2 + 2*FRAME_BITS)*CLK_DIV + 1 MCLK cycles. Outputs change only in COMMIT,
//   and both players update together.
//  Mapping: joystick1[i] = frame[i] and joystick2[i] = frame[FRAME_BITS/2 + i], for i < FRAME_BITS/2.
//  Frame bit 0 is the first bit sampled.
//  JOY_DATA is sampled raw. The adapter holds the line stable for a whole tick, so no synchroniser
//   is needed beyond the one sample flop; MATCH filters any metastable or noisy frame.
//  Elaboration check: FRAME_BITS even and <=32; POLL_CYCLES > frame length; else $error.
// STRUCTURE
//  Shared package db15_pkg: FSM state enum, button bit-index constants (BTN_R..BTN_SEL),
//   and the frame-length function used by the RTL and the bench.
//  One sub-module: tick_divider (tick counter with restart input, emits tick_end).
//  Top keeps the FSM, shift register, prev-frame register and output registers.
// TESTING  (CLK_DIV=4, FRAME_BITS=24, POLL_CYCLES=1000, MATCH=1 unless stated)
//  1 Reset, idle line (JOY_DATA=1): JOY_LOAD falls at cycle 1000.
//    frame_done fires at cycle 1000+201. Outputs stay 16'h0000 throughout.
//  2 Adapter model presents P1=12'hFFE (R pressed), P2=12'hFDF (B1 pressed) for two frames.
//    After frame 1 the outputs are unchanged. After frame 2: joystick1=16'h0001, joystick2=16'h0020.
//  3 MATCH=1, alternate P1 patterns 12'hFFE / 12'hFFD every frame:
//    outputs never leave their prior value. With MATCH=0 they follow each frame.
//  4 Check waveform: JOY_LOAD low for exactly 4 cycles, 24 JOY_CLK high pulses of 4 cycles each.
//    Data sampled 1 cycle before each rising edge.
//  5 Assert RESET for 1 cycle during bit 10 of a frame: JOY_CLK=0 and JOY_LOAD=1 next cycle,
//    outputs 0, no frame_done. The next frame starts 1000 cycles later.
//  6 POLL_CYCLES=150 (elaboration must $error). POLL_CYCLES=202: one frame starts per poll
//    and busy drops exactly 1 cycle before the next LOAD.

Source files
------------

// File: rtl/db15_serial_reader_pkg.sv
// Shared definitions for the DB15 arcade-stick serial reader: FSM states,
// button bit positions in each joystick word, and the frame-length helper.
// No logic, no latency, no flow control.
package db15_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SHLO   = 3'd3,
        ST_SHHI   = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    // Bit positions inside joystick1/joystick2.
    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B0    = 4;
    localparam int BTN_B1    = 5;
    localparam int BTN_B2    = 6;
    localparam int BTN_B3    = 7;
    localparam int BTN_B4    = 8;
    localparam int BTN_B5    = 9;
    localparam int BTN_START = 10;
    localparam int BTN_SEL   = 11;

    // MCLK cycles from LOAD entry to the end of COMMIT, inclusive.
    function automatic int frame_len(input int clk_div, input int frame_bits);
        return (2 + 2 * frame_bits) * clk_div + 1;
    endfunction

endpackage

// File: rtl/db15_serial_reader_tick_divider.sv
// Tick divider: counts MCLK cycles within one serial phase; tick_end_o marks its last cycle.
// Latency: tick_end_o is combinational from the count; restart_i zeroes the count next cycle.
// Backpressure: none, free-running.
// Ports: clk_i/rst_i (sync, active-high), restart_i (state entry), tick_end_o.
module tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_end_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_end_o = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/db15_serial_reader.sv
// DB15 reader: polls two chained 74x165s, shifts one frame in, publishes debounced joystick words.
// Latency: one frame of (2+2*FRAME_BITS)*CLK_DIV+1 cycles per poll; outputs update the cycle after COMMIT.
// Backpressure: none; a poll that lands while a frame is running is dropped.
// Ports: MCLK/RESET (sync, active-high), JOY_DATA in (active-low), JOY_CLK/JOY_LOAD to adapter,
//        joystick1/joystick2 (active-high), frame_done pulse, busy.
module db15_serial_reader
    import db15_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BITS  = 24,
    parameter int POLL_CYCLES = 48000,
    parameter int MATCH       = 1
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done,
    output logic        busy
);

    localparam int HALF      = FRAME_BITS / 2;
    localparam int KW        = $clog2(FRAME_BITS);
    localparam int PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int FRAME_LEN = frame_len(CLK_DIV, FRAME_BITS);

    generate
        if ((FRAME_BITS % 2) != 0 || FRAME_BITS > 32 || POLL_CYCLES <= FRAME_LEN) begin : g_bad_params
            $error("db15_serial_reader: FRAME_BITS must be even and <=32, POLL_CYCLES must exceed frame length");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [KW-1:0]         bit_q, bit_d;
    logic [PW-1:0]         poll_q, poll_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] prev_q, prev_d;
    logic [15:0]           joy1_q, joy1_d, joy2_q, joy2_d;
    logic                  joy_clk_q, joy_clk_d;
    logic                  joy_load_q, joy_load_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  tick_end;
    logic                  poll_wrap;

    // Every state change restarts the tick, so each phase lasts exactly CLK_DIV cycles.
    tick_divider #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i      (MCLK),
        .rst_i      (RESET),
        .restart_i  (state_d != state_q),
        .tick_end_o (tick_end)
    );

    assign poll_wrap = (poll_q == PW'(POLL_CYCLES - 1));
    assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE:   if (poll_wrap) state_d = ST_LOAD;
            ST_LOAD:   if (tick_end) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (tick_end) begin
                    state_d = ST_SHLO;
                    bit_d   = '0;
                end
            end
            ST_SHLO:   if (tick_end) state_d = ST_SHHI;
            ST_SHHI: begin
                if (tick_end) begin
                    if (bit_q == KW'(FRAME_BITS - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_SHLO;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pin-level outputs are decoded from the next state so the flops line up with the state register.
    always_comb begin
        joy_load_d = (state_d != ST_LOAD);
        joy_clk_d  = (state_d == ST_SHHI);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_COMMIT);

        // The adapter has held the bit for the whole low phase; take it on the last cycle.
        shift_d = shift_q;
        if (state_q == ST_SHLO && tick_end) begin
            shift_d[bit_q] = ~JOY_DATA;
        end

        joy1_d = joy1_q;
        joy2_d = joy2_q;
        prev_d = prev_q;
        if (state_q == ST_COMMIT) begin
            if (MATCH == 0 || shift_q == prev_q) begin
                joy1_d            = '0;
                joy2_d            = '0;
                joy1_d[HALF-1:0]  = shift_q[HALF-1:0];
                joy2_d[HALF-1:0]  = shift_q[FRAME_BITS-1:HALF];
            end
            prev_d = shift_q;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            poll_q     <= '0;
            shift_q    <= '1;
            prev_q     <= '1;
            joy1_q     <= '0;
            joy2_q     <= '0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            poll_q     <= poll_d;
            shift_q    <= shift_d;
            prev_q     <= prev_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign JOY_CLK    = joy_clk_q;
    assign JOY_LOAD   = joy_load_q;
    assign joystick1  = joy1_q;
    assign joystick2  = joy2_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule
